piso_bit_serializer: RTL
========================

Name: piso_bit_serializer

Overview:
- Parallel-in/serial-out feeder that sits directly upstream of the serial sequence detector.
- Accepts WIDTH-bit words over a valid/ready handshake and emits them one bit per clock on `out`.
- Qualifies each bit with `out_valid`, marks word boundaries with `out_last`, and supports back-to-back words with no idle cycle.
- Counts completed words for debug and verification.

Parameters:
- WIDTH, 8, bits per input word; legal range 2..32.
- MSB_FIRST, 1, 1 = emit in_data[WIDTH-1] first; 0 = emit in_data[0] first.
- CNT_W, 16, width of the completed-word counter.

Ports:
- clk  input  1  single system clock; all state updates on its rising edge.
- reset  input  1  synchronous, active-high reset.
- in_data  input  WIDTH  parallel word to serialize.
- in_valid  input  1  in_data is valid this cycle.
- in_ready  output  1  block accepts in_data this cycle; a transfer occurs when in_valid && in_ready at a rising edge.
- stall  input  1  downstream pause; freezes the shifter.
- out  output  1  current serial bit (feeds the detector's `in`).
- out_valid  output  1  `out` is a new bit this cycle and must be consumed exactly once.
- out_last  output  1  `out` is the final bit of the current word.
- busy  output  1  a word is in flight (state SHIFT).
- word_cnt  output  CNT_W  number of fully emitted words; wraps modulo 2^CNT_W.

Behaviour:
- State machine has two states, IDLE and SHIFT. Registers: shift register sh[WIDTH], bit index cnt[clog2(WIDTH)], word_cnt.
- Reset (reset=1 at an edge), regardless of state or stall:
  - state=IDLE, sh=0, cnt=0, word_cnt=0.
  - Any partially sent word is discarded, with no further bits emitted.
  - While reset is high: in_ready=0, out_valid=0, out_last=0, out=0, busy=0.
- Combinational outputs:
  - out_valid = (state==SHIFT) && !stall.
  - out = sh[WIDTH-1] if MSB_FIRST, else sh[0]; forced 0 when state==IDLE. While state==SHIFT, out shows the held bit even when stall=1.
  - out_last = (state==SHIFT) && (cnt==WIDTH-1).
  - busy = (state==SHIFT).
  - in_ready = !reset && ((state==IDLE) || (out_valid && out_last)).
- IDLE:
  - On accept: sh<=in_data, cnt<=0, go to SHIFT.
  - Otherwise stay in IDLE.
- SHIFT with stall=1:
  - sh, cnt, state and word_cnt hold; no bit is consumed.
  - in_ready=0, even on the last bit.
- SHIFT with stall=0 and cnt<WIDTH-1:
  - Shift toward the output end (left if MSB_FIRST, right otherwise), zero-filling.
  - cnt<=cnt+1.
- SHIFT with stall=0 and cnt==WIDTH-1:
  - word_cnt<=word_cnt+1 (wraps).
  - If in_valid: load sh<=in_data, cnt<=0, stay in SHIFT (zero-gap back-to-back).
  - Else: go to IDLE.
- Latency: a word accepted at edge k has its first bit on `out` with out_valid=1 in the cycle after edge k. An unstalled word occupies exactly WIDTH consecutive cycles; sustained throughput is 1 bit/clock.
- in_data is sampled only on the accepting edge; later changes have no effect on the word in flight.
- in_valid while in_ready=0 is ignored. The upstream holds in_data/in_valid until accepted; the block never drops an offered word except on reset.
- Stall in IDLE has no effect; a word can still be accepted.
- word_cnt counts only words whose last bit was emitted with out_valid=1. Words cut off by reset are not counted.

Test Plan:
1. Reset, then in_data=8'hA5 with in_valid=1 for one cycle, no stall: over 8 consecutive cycles out=1,0,1,0,0,1,0,1 with out_valid=1; out_last=1 only on the 8th; then IDLE with out=0, busy=0; word_cnt=1.
2. Back-to-back 8'h0A then 8'hA0, in_valid held high: 16 contiguous valid bits 0000_1010_1010_0000 with no gap; in_ready=1 only in the first IDLE cycle and on cycle 8; out_last on cycles 8 and 16; word_cnt=2. Fed into the detector, its output pulses exactly where the overlapping 1010 patterns end.
3. Word 8'hF0 with stall=1 for 3 cycles after the 2nd bit: out holds 1 with out_valid=0 during the stall; the consumed sequence is still 1,1,1,1,0,0,0,0 and total duration is 11 cycles.
4. Reset asserted after 3 bits of 8'hFF: next cycle out_valid=0, busy=0, word_cnt=0, no residual bits; a following word 8'h81 serializes cleanly as 1,0,0,0,0,0,0,1.
5. MSB_FIRST=0, in_data=8'h01: out=1,0,0,0,0,0,0,0. Also stall=1 on the last bit: in_ready=0 until stall drops.
6. CNT_W=4, 17 words streamed back-to-back: word_cnt wraps 15→0 and reads 1 at the end.

Source files
------------

// File: rtl/piso_bit_serializer.sv
// piso_bit_serializer: parallel-in / serial-out feeder for the serial sequence detector.
// Latency: word accepted at edge k shows its first bit in the cycle after edge k; 1 bit/clock sustained.
// Backpressure: in_ready drops while a word is in flight; stall freezes the shifter and holds the current bit.
//
// Ports:
//   clk, reset          - rising-edge clock, synchronous active-high reset
//   in_data/in_valid    - parallel word offered upstream; transfer on in_valid && in_ready
//   in_ready            - high in IDLE, or on an unstalled last bit (zero-gap reload)
//   stall               - downstream pause; holds sh/cnt/state/word_cnt while in SHIFT
//   out/out_valid       - serial bit and its qualifier (each valid bit consumed once)
//   out_last            - current bit is the final bit of the word
//   busy                - a word is in flight
//   word_cnt            - number of fully emitted words, wraps modulo 2^CNT_W
module piso_bit_serializer #(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1,
  parameter int CNT_W     = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             stall,
  output logic             out,
  output logic             out_valid,
  output logic             out_last,
  output logic             busy,
  output logic [CNT_W-1:0] word_cnt
);

  localparam int            IW       = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(WIDTH - 1);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t          state;
  logic [WIDTH-1:0] sh;
  logic [IW-1:0]    cnt;

  logic             in_shift;
  logic             head_bit;
  logic [WIDTH-1:0] sh_next;

  // Reset is synchronous, so the state register may still read SHIFT while
  // reset is high; every output is gated so nothing leaks during that cycle.
  assign in_shift  = !reset && (state == SHIFT);
  assign busy      = in_shift;
  assign out_valid = in_shift && !stall;
  assign out_last  = in_shift && (cnt == LAST_IDX);

  assign head_bit  = MSB_FIRST ? sh[WIDTH-1] : sh[0];
  // Held bit stays visible under stall; only IDLE forces the line low.
  assign out       = in_shift && head_bit;

  // A stalled last bit is not consumed, so no reload slot is offered then.
  assign in_ready  = !reset && ((state == IDLE) || (out_valid && out_last));

  // Shift toward the output end with zero fill.
  assign sh_next   = MSB_FIRST ? {sh[WIDTH-2:0], 1'b0} : {1'b0, sh[WIDTH-1:1]};

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      sh       <= '0;
      cnt      <= '0;
      word_cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            sh    <= in_data;
            cnt   <= '0;
            state <= SHIFT;
          end
        end
        SHIFT: begin
          if (!stall) begin
            if (cnt != LAST_IDX) begin
              sh  <= sh_next;
              cnt <= cnt + IW'(1);
            end else begin
              // Last bit consumed: count it, then reload back-to-back or go idle.
              word_cnt <= word_cnt + CNT_W'(1);
              if (in_valid) begin
                sh  <= in_data;
                cnt <= '0;
              end else begin
                state <= IDLE;
              end
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
